psum_accumulator: RTL and testbench
===================================

Name: psum_accumulator

Overview:
- Sits directly downstream of the 5-bit-to-4-bit macro output decoder.
- Each beat, it consumes one bit-plane's decoded 4-bit signed partial sums for every channel and every macro.
- Per channel, it reduces across macros, applies the bit-plane shift (and sign weighting on the MSB plane), and accumulates with saturation over a group of beats.
- The completed per-channel sums are presented to the next layer stage through a valid/ready handshake.

Parameters:
- CHANNEL_NUM, 128: channels per macro.
- MACRO_NUM, 4: macros reduced per channel.
- ACT_BITS, 4: activation bit-planes per input vector, range 1..8.
- SIGNED_ACT, 1: 1 = MSB plane carries negative weight (two's-complement activations); 0 = unsigned.
- ACC_W, 16: accumulator and output width, signed.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_last  in  1  final beat of the accumulation group.
- data_in  in  [3:0][CHANNEL_NUM-1:0][MACRO_NUM-1:0]  decoder outputs, two's complement, range -8..7.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- data_out  out  [ACC_W-1:0][CHANNEL_NUM-1:0]  accumulated signed sums.
- out_sat  out  [CHANNEL_NUM-1:0]  per-channel saturation occurred in this group.
- err_align  out  1  sticky flag: in_last arrived on a plane other than ACT_BITS-1.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high; clock and reset ports are clk and rst.
- Reset values:
  - in_ready=0 during the reset cycle, 1 in the first cycle after rst deasserts.
  - out_valid=0, data_out=0, out_sat=0, err_align=0.
  - Plane counter=0, first-beat flag=1, FSM state=IDLE.
- FSM states: IDLE, ACCUM, HOLD.
  - IDLE: in_ready=1. An accepted beat (in_valid&in_ready) loads the accumulator with its term instead of adding to it, then goes to ACCUM. If that beat also has in_last, go straight to HOLD.
  - ACCUM: in_ready=1. Each accepted beat adds its term. A beat with in_last goes to HOLD after its term is applied.
  - HOLD: in_ready=0 and out_valid=1. data_out and out_sat are stable and must not change. When out_ready=1, go to IDLE with out_valid=0 in the next cycle. The plane counter resets to 0.
- Beat transfer:
  - A transfer occurs only when in_valid&in_ready.
  - With no transfer, the accumulator and plane counter hold.
  - in_valid gaps are allowed anywhere inside a group.
- Per-channel term:
  - msum = sum over MACRO_NUM of sign-extended data_in, 7-bit signed.
  - shifted = msum << plane, sign-extended to ACC_W+1.
  - If SIGNED_ACT=1 and plane==ACT_BITS-1, term = -shifted; otherwise term = shifted.
- Accumulate:
  - next = acc + term, computed at ACC_W+1 bits.
  - If next > 2^(ACC_W-1)-1, clamp to the max value; if next < -2^(ACC_W-1), clamp to the min value.
  - On any clamp, set that channel's out_sat bit. out_sat clears on the first beat of the next group.
- Plane counter:
  - Increments on every accepted beat and wraps from ACT_BITS-1 to 0.
  - Resets to 0 after a group completes, i.e. on the in_last beat.
- Alignment error:
  - If in_last is accepted while plane != ACT_BITS-1, set err_align and still complete the group normally.
  - err_align clears only on rst.
- Latency: data_out is valid in the cycle after the accepted in_last beat. Throughput is one beat per cycle, plus a minimum of one HOLD cycle per group.
- Reset mid-operation: rst in any state returns all registers to their reset values on that edge. Any partial accumulation is discarded and nothing is output for it.
- Continuing and idle cycles:
  - HOLD with out_ready held high lasts exactly 1 cycle.
  - An in_valid asserted during HOLD is not accepted; the source must hold it until in_ready rises.

Test Plan:
- Reset, then one group of ACT_BITS=4 beats, all data_in=1, SIGNED_ACT=1:
  - msum=4 for every beat.
  - Result 4+8+16-32=-4 on every channel.
  - out_valid rises 1 cycle after the in_last beat.
- Unsigned mode (SIGNED_ACT=0), same stimulus -> 4+8+16+32=60. out_sat=0.
- 40 consecutive 4-plane groups merged into one group (in_last only on beat 160), all data_in=7, SIGNED_ACT=0, ACC_W=10:
  - Result clamps to 511 and out_sat=all ones.
  - The next group starts with out_sat cleared.
- in_valid toggled 1-0-1-0 within a group, plus out_ready held low for 5 cycles:
  - Same result as the gap-free case.
  - data_out stable and in_ready=0 throughout HOLD.
- in_last on the 2nd beat with ACT_BITS=4 -> err_align=1 (sticky), result = beats 0..1 accumulated. The next group starts at plane 0.
- rst asserted for one cycle after beat 2 of a group, then a fresh group of all data_in=-8, SIGNED_ACT=1, ACT_BITS=4:
  - msum=-32.
  - Result -32-64-128+256=32, with no contribution from the pre-reset beats.

Source files
------------

// File: rtl/psum_accumulator.sv
// psum_accumulator: per-channel reduction of decoded macro partial sums across
// macros and activation bit-planes, with saturating accumulation over a group
// of beats and a valid/ready result interface.
module psum_accumulator #(
    parameter int CHANNEL_NUM = 128,
    parameter int MACRO_NUM   = 4,
    parameter int ACT_BITS    = 4,
    parameter int SIGNED_ACT  = 1,
    parameter int ACC_W       = 16
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        in_valid,
    output logic                                        in_ready,
    input  logic                                        in_last,
    input  logic [3:0][CHANNEL_NUM-1:0][MACRO_NUM-1:0]  data_in,
    output logic                                        out_valid,
    input  logic                                        out_ready,
    output logic [ACC_W-1:0][CHANNEL_NUM-1:0]           data_out,
    output logic [CHANNEL_NUM-1:0]                      out_sat,
    output logic                                        err_align
);

    localparam int PW = (ACT_BITS > 1) ? $clog2(ACT_BITS) : 1;
    localparam int TW = ACC_W + 1;
    localparam logic [PW-1:0]          LAST_PLANE = PW'(ACT_BITS - 1);
    localparam logic signed [TW-1:0]   ACC_MAX    = {2'b00, {(ACC_W-1){1'b1}}};
    localparam logic signed [TW-1:0]   ACC_MIN    = {2'b11, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t                   r_state;
    logic [PW-1:0]            r_plane;
    logic                     r_first;
    logic signed [ACC_W-1:0]  r_acc [CHANNEL_NUM];
    logic [CHANNEL_NUM-1:0]   r_sat;
    logic                     r_in_ready;
    logic                     r_out_valid;
    logic                     r_err_align;

    logic                     w_fire;
    logic                     w_neg;
    logic signed [ACC_W-1:0]  w_acc_next [CHANNEL_NUM];
    logic [CHANNEL_NUM-1:0]   w_clamp;

    assign w_fire = in_valid & r_in_ready;
    // The MSB plane of a two's-complement activation carries negative weight.
    assign w_neg  = (SIGNED_ACT != 0) && (r_plane == LAST_PLANE);

    // Per-channel term (macro sum, plane shift, sign) and saturating next value.
    always_comb begin
        logic [3:0]              v_nib;
        logic signed [6:0]       v_msum;
        logic signed [TW-1:0]    v_ext;
        logic signed [TW-1:0]    v_shift;
        logic signed [TW-1:0]    v_term;
        logic signed [TW-1:0]    v_base;
        logic signed [TW-1:0]    v_sum;
        // NOTE: every combinational output and temporary gets a default before
        // any branch, so no path leaves a value held and no latch is inferred.
        v_nib   = '0;
        v_msum  = '0;
        v_ext   = '0;
        v_shift = '0;
        v_term  = '0;
        v_base  = '0;
        v_sum   = '0;
        w_clamp = '0;
        for (int c = 0; c < CHANNEL_NUM; c++) begin
            w_acc_next[c] = '0;
        end
        for (int c = 0; c < CHANNEL_NUM; c++) begin
            v_msum = '0;
            for (int m = 0; m < MACRO_NUM; m++) begin
                for (int b = 0; b < 4; b++) begin
                    v_nib[b] = data_in[b][c][m];
                end
                v_msum = v_msum + {{3{v_nib[3]}}, v_nib};
            end
            v_ext   = {{(TW-7){v_msum[6]}}, v_msum};
            v_shift = v_ext << r_plane;
            v_term  = w_neg ? -v_shift : v_shift;
            // The first beat of a group loads the term rather than adding it.
            v_base  = r_first ? '0 : {r_acc[c][ACC_W-1], r_acc[c]};
            v_sum   = v_base + v_term;
            if (v_sum > ACC_MAX) begin
                w_acc_next[c] = ACC_MAX[ACC_W-1:0];
                w_clamp[c]    = 1'b1;
            end else if (v_sum < ACC_MIN) begin
                w_acc_next[c] = ACC_MIN[ACC_W-1:0];
                w_clamp[c]    = 1'b1;
            end else begin
                w_acc_next[c] = v_sum[ACC_W-1:0];
            end
        end
    end

    // Group FSM, plane counter, accumulators and registered handshake outputs.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments only, so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            r_state     <= IDLE;
            r_plane     <= '0;
            r_first     <= 1'b1;
            r_sat       <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_err_align <= 1'b0;
            // NOTE: the accumulator array is reset because it drives data_out
            // directly and data_out must read zero out of reset.
            for (int c = 0; c < CHANNEL_NUM; c++) begin
                r_acc[c] <= '0;
            end
        end else begin
            case (r_state)
                IDLE, ACCUM: begin
                    r_in_ready <= 1'b1;
                    if (w_fire) begin
                        for (int c = 0; c < CHANNEL_NUM; c++) begin
                            r_acc[c] <= w_acc_next[c];
                        end
                        r_sat   <= (r_first ? '0 : r_sat) | w_clamp;
                        r_first <= in_last;
                        if (in_last) begin
                            r_plane     <= '0;
                            r_state     <= HOLD;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                            if (r_plane != LAST_PLANE) begin
                                r_err_align <= 1'b1;
                            end
                        end else begin
                            r_plane <= (r_plane == LAST_PLANE) ? '0 : PW'(r_plane + 1'b1);
                            r_state <= ACCUM;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Present the accumulators in the bit-major output layout.
    always_comb begin
        data_out = '0;
        for (int c = 0; c < CHANNEL_NUM; c++) begin
            for (int b = 0; b < ACC_W; b++) begin
                data_out[b][c] = r_acc[c][b];
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_sat   = r_sat;
    assign err_align = r_err_align;

endmodule

// File: tb/tb_psum_accumulator.sv
// Self-checking bench for psum_accumulator: a signed-activation and an
// unsigned-activation instance share one stimulus stream; a behavioural model
// queues expected group results and a monitor compares them on each handshake.
module tb_psum_accumulator;

    localparam int CH = 8;
    localparam int MN = 4;
    localparam int AB = 4;
    localparam int AW = 10;
    localparam int MAXV = (1 << (AW - 1)) - 1;
    localparam int MINV = -(1 << (AW - 1));

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic in_last = 1'b0;
    logic out_ready = 1'b1;
    logic [3:0][CH-1:0][MN-1:0] data_in = '0;

    logic in_ready_s, in_ready_u, out_valid_s, out_valid_u, err_s, err_u;
    logic [AW-1:0][CH-1:0] dout_s, dout_u;
    logic [CH-1:0] sat_s, sat_u;

    always #5 clk = ~clk;

    psum_accumulator #(.CHANNEL_NUM(CH), .MACRO_NUM(MN), .ACT_BITS(AB),
                       .SIGNED_ACT(1), .ACC_W(AW)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_last(in_last), .data_in(data_in), .out_valid(out_valid_s),
        .out_ready(out_ready), .data_out(dout_s), .out_sat(sat_s),
        .err_align(err_s));

    psum_accumulator #(.CHANNEL_NUM(CH), .MACRO_NUM(MN), .ACT_BITS(AB),
                       .SIGNED_ACT(0), .ACC_W(AW)) dut_u (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_u),
        .in_last(in_last), .data_in(data_in), .out_valid(out_valid_u),
        .out_ready(out_ready), .data_out(dout_u), .out_sat(sat_u),
        .err_align(err_u));

    typedef struct packed {
        logic [CH-1:0][AW-1:0] val;
        logic [CH-1:0]         sat;
    } exp_t;

    exp_t q_s[$];
    exp_t q_u[$];
    int   total = 0;
    int   bad = 0;

    // Reference model state: plain integer accumulation per instance/channel.
    int cur_d [CH][MN];
    int m_acc [2][CH];
    bit m_sat [2][CH];
    bit m_first;
    int m_plane;
    bit m_err;

    task automatic check(input string name, input logic signed [127:0] got,
                         input logic signed [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
        end
    endtask

    function automatic int ch_val(input logic [AW-1:0][CH-1:0] d, input int c);
        logic [AW-1:0] v;
        for (int b = 0; b < AW; b++) v[b] = d[b][c];
        return int'(signed'(v));
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++)
            for (int c = 0; c < CH; c++) begin
                m_acc[k][c] = 0;
                m_sat[k][c] = 1'b0;
            end
        m_first = 1'b1;
        m_plane = 0;
        m_err   = 1'b0;
        q_s.delete();
        q_u.delete();
    endtask

    // Apply one accepted beat to the model (k=0 signed, k=1 unsigned).
    task automatic model_beat(input bit last);
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < CH; c++) begin
                int msum, term;
                msum = 0;
                for (int m = 0; m < MN; m++) msum += cur_d[c][m];
                term = msum * (1 << m_plane);
                if (k == 0 && m_plane == AB - 1) term = -term;
                if (m_first) begin
                    m_acc[k][c] = 0;
                    m_sat[k][c] = 1'b0;
                end
                m_acc[k][c] += term;
                if (m_acc[k][c] > MAXV) begin
                    m_acc[k][c] = MAXV;
                    m_sat[k][c] = 1'b1;
                end else if (m_acc[k][c] < MINV) begin
                    m_acc[k][c] = MINV;
                    m_sat[k][c] = 1'b1;
                end
            end
            if (last) begin
                for (int c = 0; c < CH; c++) begin
                    e.val[c] = AW'(m_acc[k][c]);
                    e.sat[c] = m_sat[k][c];
                end
                if (k == 0) q_s.push_back(e);
                else        q_u.push_back(e);
            end
        end
        if (last) begin
            if (m_plane != AB - 1) m_err = 1'b1;
            m_plane = 0;
            m_first = 1'b1;
        end else begin
            m_plane = (m_plane + 1) % AB;
            m_first = 1'b0;
        end
    endtask

    task automatic fill_const(input int v);
        for (int c = 0; c < CH; c++)
            for (int m = 0; m < MN; m++) cur_d[c][m] = v;
    endtask

    task automatic fill_rand();
        for (int c = 0; c < CH; c++)
            for (int m = 0; m < MN; m++) cur_d[c][m] = int'($urandom_range(0, 15)) - 8;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Drive one beat and hold it until accepted (bounded wait).
    task automatic send_beat(input bit last);
        int n;
        @(negedge clk);
        for (int c = 0; c < CH; c++)
            for (int m = 0; m < MN; m++) begin
                logic [3:0] nib;
                nib = 4'(cur_d[c][m]);
                for (int b = 0; b < 4; b++) data_in[b][c][m] = nib[b];
            end
        in_valid = 1'b1;
        in_last  = last;
        n = 0;
        while (!in_ready_s && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            check("in_ready_timeout", n, 0);
            in_valid = 1'b0;
            in_last  = 1'b0;
        end else begin
            @(posedge clk);
            model_beat(last);
            #1;
            if (last) begin
                check("latency_valid_s", out_valid_s, 1);
                check("latency_valid_u", out_valid_u, 1);
            end
        end
    endtask

    task automatic send_group(input int len);
        for (int i = 0; i < len; i++) send_beat(i == len - 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        while (out_valid_s && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("drain_timeout", n, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(negedge clk);
        check("rst_in_ready", in_ready_s, 0);
        check("rst_out_valid", out_valid_s, 0);
        check("rst_data_out_s", dout_s, 0);
        check("rst_data_out_u", dout_u, 0);
        check("rst_out_sat", sat_s, 0);
        check("rst_err_align", err_s, 0);
        model_reset();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", in_ready_s, 1);
    endtask

    // Monitor: compares each handed-off result and checks HOLD stability.
    logic [AW-1:0][CH-1:0] prev_d [2];
    logic [CH-1:0]         prev_sat [2];
    bit                    prev_hold [2];

    initial begin
        prev_hold[0] = 1'b0;
        prev_hold[1] = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            for (int k = 0; k < 2; k++) begin
                logic                  ov, ir;
                logic [AW-1:0][CH-1:0] d;
                logic [CH-1:0]         st;
                exp_t                  e;
                ov = (k == 0) ? out_valid_s : out_valid_u;
                ir = (k == 0) ? in_ready_s  : in_ready_u;
                d  = (k == 0) ? dout_s      : dout_u;
                st = (k == 0) ? sat_s       : sat_u;
                if (rst || !ov) begin
                    prev_hold[k] = 1'b0;
                end else begin
                    check("hold_in_ready", ir, 0);
                    if (prev_hold[k]) begin
                        check("hold_data_stable", d, prev_d[k]);
                        check("hold_sat_stable", st, prev_sat[k]);
                    end
                    if (out_ready) begin
                        int sz;
                        sz = (k == 0) ? q_s.size() : q_u.size();
                        check("result_expected", sz > 0, 1);
                        if (sz > 0) begin
                            e = (k == 0) ? q_s.pop_front() : q_u.pop_front();
                            for (int c = 0; c < CH; c++)
                                check((k == 0) ? "data_s" : "data_u", ch_val(d, c),
                                      int'(signed'(e.val[c])));
                            check((k == 0) ? "sat_s" : "sat_u", st, e.sat);
                        end
                        prev_hold[k] = 1'b0;
                    end else begin
                        prev_hold[k] = 1'b1;
                        prev_d[k]    = d;
                        prev_sat[k]  = st;
                    end
                end
            end
        end
    end

    initial begin
        int len;
        model_reset();
        do_reset();

        // All-ones group: signed -4, unsigned 60.
        out_ready = 1'b1;
        fill_const(1);
        send_group(4);
        check("ones_signed", ch_val(dout_s, 0), -4);
        check("ones_unsigned", ch_val(dout_u, CH - 1), 60);
        check("ones_unsigned_sat", sat_u, 0);
        wait_idle();

        // 160-beat group of 7s saturates.
        fill_const(7);
        send_group(160);
        check("sat_unsigned_val", ch_val(dout_u, 3), MAXV);
        check("sat_unsigned_flag", sat_u, {CH{1'b1}});
        check("sat_signed_val", ch_val(dout_s, 3), MINV);
        wait_idle();

        // Next group clears out_sat.
        fill_const(1);
        send_group(4);
        check("sat_cleared", sat_u, 0);
        wait_idle();

        // Gaps inside a group, result stalled for 5 cycles with in_valid held.
        out_ready = 1'b0;
        fill_const(1);
        send_beat(1'b0);
        idle_cycle();
        send_beat(1'b0);
        idle_cycle();
        send_beat(1'b0);
        send_beat(1'b1);
        check("gap_signed", ch_val(dout_s, 1), -4);
        check("gap_unsigned", ch_val(dout_u, 1), 60);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_last  = 1'b0;
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_idle();

        // Misaligned in_last on the 2nd beat.
        check("err_before", err_s, 0);
        fill_const(2);
        send_group(2);
        check("misalign_val", ch_val(dout_s, 2), 24);
        check("err_set_s", err_s, 1);
        check("err_set_u", err_u, 1);
        wait_idle();
        fill_const(1);
        send_group(4);
        check("realign_val", ch_val(dout_s, 0), -4);
        check("err_sticky", err_s, 1);
        wait_idle();

        // Reset mid-group discards partial work.
        fill_rand();
        send_beat(1'b0);
        send_beat(1'b0);
        send_beat(1'b0);
        do_reset();
        fill_const(-8);
        send_group(4);
        check("neg8_signed", ch_val(dout_s, 5), 32);
        check("neg8_unsigned", ch_val(dout_u, 5), -480);
        wait_idle();

        // Randomised groups with gaps and output stalls.
        for (int g = 0; g < 40; g++) begin
            out_ready = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 9)) : AB;
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 3) == 0) idle_cycle();
                fill_rand();
                send_beat(i == len - 1);
            end
            if (!out_ready) begin
                repeat ($urandom_range(1, 4)) @(negedge clk);
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end
            wait_idle();
        end

        repeat (3) @(negedge clk);
        check("queue_s_drained", q_s.size(), 0);
        check("queue_u_drained", q_u.size(), 0);
        check("err_final_s", err_s, m_err);
        check("err_final_u", err_u, m_err);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
